// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader. Assembles a byte stream (high byte first) into
//   16-bit instruction words and writes them into instruction memory at
//   consecutive even byte addresses. The CPU is held while a load is in
//   progress. A load ends in DONE when HALT_WORD has been written, or in ERR
//   when DEPTH words were written without seeing HALT_WORD.
//
// Ports
//   clock       in   system clock, rising-edge
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle load request (honoured in IDLE/DONE/ERR)
//   byte_valid  in   source presents a program byte
//   byte_data   in   [7:0] program byte
//   byte_ready  out  loader accepts a byte this cycle (HI/LO only)
//   wr_en       out  instruction-memory write strobe, one cycle per word
//   wr_addr     out  [15:0] byte address of the word being written
//   wr_data     out  [15:0] instruction word being written
//   cpu_hold    out  keeps the CPU PC frozen during a load or after an error
//   done        out  load completed with HALT_WORD written
//   error       out  DEPTH words written without HALT_WORD
//   word_count  out  [15:0] words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Count value held while the DEPTH-th word is being written.
  localparam logic [15:0] LAST_CNT = 16'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] word_count_q, word_count_d;

  logic        byte_ready_q, byte_ready_d;
  logic        wr_en_q, wr_en_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        idle_like_s;

  assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERR);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. byte_ready is 1 in HI/LO, so a transfer there is just
  // byte_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_HI: begin
        if (byte_valid) begin
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (byte_valid) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_WRITE: begin
        // HALT_WORD wins over the depth limit on the final word.
        if (wr_data_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (word_count_q == LAST_CNT) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every flag leaves a flop and lines
  // up exactly with the state it describes.
  always_comb begin
    byte_ready_d = 1'b0;
    wr_en_d      = 1'b0;
    cpu_hold_d   = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    case (state_d)
      ST_IDLE:  begin end
      ST_HI:    begin byte_ready_d = 1'b1; cpu_hold_d = 1'b1; end
      ST_LO:    begin byte_ready_d = 1'b1; cpu_hold_d = 1'b1; end
      ST_WRITE: begin wr_en_d      = 1'b1; cpu_hold_d = 1'b1; end
      ST_DONE:  begin done_d       = 1'b1; end
      ST_ERR:   begin error_d      = 1'b1; cpu_hold_d = 1'b1; end
      default:  begin end
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Datapath next-state: word assembly, address and count bookkeeping.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          wr_addr_d    = 16'd0;
          word_count_d = 16'd0;
        end else begin
          wr_addr_d    = wr_addr_q;
          word_count_d = word_count_q;
        end
      end
      ST_HI: begin
        if (byte_valid) begin
          wr_data_d[15:8] = byte_data;
        end else begin
          wr_data_d = wr_data_q;
        end
      end
      ST_LO: begin
        if (byte_valid) begin
          wr_data_d[7:0] = byte_data;
        end else begin
          wr_data_d = wr_data_q;
        end
      end
      ST_WRITE: begin
        word_count_d = word_count_q + 16'd1;
        wr_addr_d    = wr_addr_q + 16'd2;
      end
      default: begin
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 16'd0;
      word_count_q <= 16'd0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Two instances share the stimulus:
//   dut_a with the default DEPTH=1024 and dut_b with DEPTH=4 for the
//   depth-limit cases. Inputs change on the falling edge; outputs are
//   sampled on the falling edge, half a cycle after the active edge.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        a_byte_ready, a_wr_en, a_cpu_hold, a_done, a_error;
  logic [15:0] a_wr_addr, a_wr_data, a_word_count;
  logic        b_byte_ready, b_wr_en, b_cpu_hold, b_done, b_error;
  logic [15:0] b_wr_addr, b_wr_data, b_word_count;

  int          total;
  int          passed;
  int          fails;
  logic [15:0] words [0:7];

  imem_loader dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(a_byte_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .cpu_hold(a_cpu_hold), .done(a_done),
    .error(a_error), .word_count(a_word_count)
  );

  imem_loader #(.DEPTH(4), .HALT_WORD(16'hFFFF)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(b_byte_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .cpu_hold(b_cpu_hold), .done(b_done),
    .error(b_error), .word_count(b_word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: through the active edge to the following falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // Start a load and stream words[0..n-1] back-to-back with byte_valid high.
  // Expect nwr writes, one every third cycle, at addresses 0,2,4,...
  task automatic stream(input int n, input int nwr, input bit sel,
                        input string tag);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = words[0][15:8];
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3 * nwr + 3; k++) begin
      int   w;
      int   ph;
      int   idx;
      logic wr_s;
      logic [15:0] addr_s;
      logic [15:0] data_s;
      w   = (k - 1) / 3;
      ph  = (k - 1) % 3;
      idx = (ph == 2) ? w + 1 : w;
      if (idx < n) begin
        byte_valid = 1'b1;
        byte_data  = (ph == 1) ? words[idx][7:0] : words[idx][15:8];
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
      end
      cyc();
      wr_s   = sel ? b_wr_en   : a_wr_en;
      addr_s = sel ? b_wr_addr : a_wr_addr;
      data_s = sel ? b_wr_data : a_wr_data;
      check($sformatf("%s wr_en k=%0d", tag, k), 32'(wr_s),
            32'((ph == 1 && w < nwr) ? 1 : 0));
      if (ph == 1 && w < nwr) begin
        check($sformatf("%s wr_addr w=%0d", tag, w), 32'(addr_s), 32'(2 * w));
        check($sformatf("%s wr_data w=%0d", tag, w), 32'(data_s), 32'(words[w]));
      end
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; fails = 0;
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    for (int i = 0; i < 8; i++) words[i] = 16'h0000;
    cyc(); cyc();

    // Reset state of both instances.
    check("rst a byte_ready", 32'(a_byte_ready), 32'd0);
    check("rst a wr_en",      32'(a_wr_en),      32'd0);
    check("rst a wr_addr",    32'(a_wr_addr),    32'd0);
    check("rst a wr_data",    32'(a_wr_data),    32'd0);
    check("rst a cpu_hold",   32'(a_cpu_hold),   32'd0);
    check("rst a done",       32'(a_done),       32'd0);
    check("rst a error",      32'(a_error),      32'd0);
    check("rst a word_count", 32'(a_word_count), 32'd0);
    check("rst b cpu_hold",   32'(b_cpu_hold),   32'd0);
    check("rst b error",      32'(b_error),      32'd0);

    // Releasing reset alone must not start a load.
    reset_n = 1'b1;
    cyc(); cyc();
    check("norst-start byte_ready", 32'(a_byte_ready), 32'd0);
    check("norst-start cpu_hold",   32'(a_cpu_hold),   32'd0);

    // Back-to-back load 71 0F 72 07 FF FF.
    words[0] = 16'h710F; words[1] = 16'h7207; words[2] = 16'hFFFF;
    stream(3, 3, 1'b0, "b2b");
    check("b2b done",       32'(a_done),       32'd1);
    check("b2b error",      32'(a_error),      32'd0);
    check("b2b word_count", 32'(a_word_count), 32'd3);
    check("b2b cpu_hold",   32'(a_cpu_hold),   32'd0);
    check("b2b byte_ready", 32'(a_byte_ready), 32'd0);

    // Restart from DONE; stall 4 cycles between high and low byte.
    start = 1'b1; byte_valid = 1'b0;
    cyc();
    start = 1'b0;
    check("stall clr word_count", 32'(a_word_count), 32'd0);
    check("stall clr wr_addr",    32'(a_wr_addr),    32'd0);
    check("stall clr done",       32'(a_done),       32'd0);
    byte_valid = 1'b1; byte_data = 8'h26;
    cyc();
    byte_valid = 1'b0; byte_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("stall byte_ready %0d", i), 32'(a_byte_ready), 32'd1);
      check($sformatf("stall wr_en %0d", i),      32'(a_wr_en),      32'd0);
    end
    byte_valid = 1'b1; byte_data = 8'h07;
    cyc();
    byte_valid = 1'b0;
    check("stall wr_en",   32'(a_wr_en),   32'd1);
    check("stall wr_data", 32'(a_wr_data), 32'h2607);
    check("stall wr_addr", 32'(a_wr_addr), 32'd0);
    cyc();
    check("stall word_count", 32'(a_word_count), 32'd1);
    check("stall next addr",  32'(a_wr_addr),    32'd2);

    // start pulsed during LO is ignored.
    do_reset();
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
    cyc();
    start = 1'b0;
    cyc();
    byte_data = 8'hBB;
    cyc();
    check("ign w0 wr_en",   32'(a_wr_en),   32'd1);
    check("ign w0 wr_data", 32'(a_wr_data), 32'hAABB);
    byte_data = 8'hCC;
    cyc();
    cyc();
    start = 1'b1; byte_data = 8'hDD;
    cyc();
    start = 1'b0; byte_valid = 1'b0;
    check("ign w1 wr_en",      32'(a_wr_en),      32'd1);
    check("ign w1 wr_addr",    32'(a_wr_addr),    32'd2);
    check("ign w1 wr_data",    32'(a_wr_data),    32'hCCDD);
    check("ign w1 word_count", 32'(a_word_count), 32'd1);
    cyc();
    check("ign word_count", 32'(a_word_count), 32'd2);
    check("ign wr_addr",    32'(a_wr_addr),    32'd4);
    check("ign cpu_hold",   32'(a_cpu_hold),   32'd1);

    // Asynchronous reset after the high byte of the second word.
    do_reset();
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h12;
    cyc();
    start = 1'b0;
    cyc();
    byte_data = 8'h34;
    cyc();
    byte_data = 8'h56;
    cyc();
    cyc();
    #2 reset_n = 1'b0;
    #1;
    check("arst byte_ready", 32'(a_byte_ready), 32'd0);
    check("arst wr_en",      32'(a_wr_en),      32'd0);
    check("arst wr_addr",    32'(a_wr_addr),    32'd0);
    check("arst wr_data",    32'(a_wr_data),    32'd0);
    check("arst cpu_hold",   32'(a_cpu_hold),   32'd0);
    check("arst word_count", 32'(a_word_count), 32'd0);
    @(negedge clock);
    byte_valid = 1'b0;
    reset_n = 1'b1;
    cyc();
    words[0] = 16'h0001; words[1] = 16'hFFFF;
    stream(2, 2, 1'b0, "arst reload");
    check("arst reload done",       32'(a_done),       32'd1);
    check("arst reload word_count", 32'(a_word_count), 32'd2);

    // DEPTH=4 overflow: five non-halt words offered, four written.
    do_reset();
    words[0] = 16'h1020; words[1] = 16'h1121; words[2] = 16'h1222;
    words[3] = 16'h1323; words[4] = 16'h1424;
    stream(5, 4, 1'b1, "ovf");
    check("ovf error",      32'(b_error),      32'd1);
    check("ovf done",       32'(b_done),       32'd0);
    check("ovf cpu_hold",   32'(b_cpu_hold),   32'd1);
    check("ovf word_count", 32'(b_word_count), 32'd4);
    check("ovf byte_ready", 32'(b_byte_ready), 32'd0);

    // DEPTH=4 with HALT_WORD as the fourth word: DONE, not ERR.
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    words[3] = 16'hFFFF;
    stream(4, 4, 1'b1, "edge");
    check("edge done",       32'(b_done),       32'd1);
    check("edge error",      32'(b_error),      32'd0);
    check("edge word_count", 32'(b_word_count), 32'd4);
    check("edge cpu_hold",   32'(b_cpu_hold),   32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction-memory capacity in 16-bit words.
REQ-002 Parameter HALT_WORD, default 16'hFFFF, end-of-program marker word.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a program load.
REQ-007 byte_valid  input  1  source presents a program byte.
REQ-008 byte_data  input  8  program byte; high byte of each word first.
REQ-009 byte_ready  output  1  loader accepts byte this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 wr_addr  output  16  byte address of the word being written, always even.
REQ-012 wr_data  output  16  instruction word being written.
REQ-013 cpu_hold  output  1  holds the CPU PC while a load is in progress.
REQ-014 done  output  1  load completed with HALT_WORD written.
REQ-015 error  output  1  DEPTH words written without HALT_WORD.
REQ-016 word_count  output  16  number of words written in the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, HI, LO, WRITE, DONE and ERR.
REQ-018 IDLE/DONE/ERR: start=1 SHALL go to HI, clear wr_addr, word_count, done and error.
REQ-019 start in HI, LO or WRITE SHALL be ignored.
REQ-020 byte_ready SHALL be 1 only in HI and LO; a byte transfers only when byte_valid and byte_ready are both 1.
REQ-021 HI: on transfer, latch byte_data into wr_data[15:8] and go to LO; otherwise stay.
REQ-022 LO: on transfer, latch byte_data into wr_data[7:0] and go to WRITE; otherwise stay.
REQ-023 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr and wr_data stable, byte_ready=0.
REQ-024 Leaving WRITE: word_count increments by 1 and wr_addr by 2 (16-bit wrap not reachable for DEPTH<=32768).
REQ-025 After WRITE: wr_data==HALT_WORD -> DONE; else word_count reaching DEPTH -> ERR; else -> HI.
REQ-026 The HALT_WORD SHALL itself be written to memory and counted.
REQ-027 If the DEPTH-th word equals HALT_WORD, the result SHALL be DONE, not ERR.
REQ-028 cpu_hold SHALL be 1 in HI, LO, WRITE and ERR; 0 in IDLE and DONE.
REQ-029 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR; both hold until the next accepted start.
REQ-030 Minimum throughput SHALL be one word per 3 cycles with byte_valid held high.
REQ-031 wr_en SHALL never assert outside WRITE.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, word_count=0.
REQ-033 Reset mid-load SHALL abandon the partial word with no further write; the next load restarts at address 0.
REQ-034 Release of reset_n SHALL not by itself start a load; start is required.

Verification
REQ-035 start, bytes 71 0F 72 07 FF FF back-to-back -> writes (0,710F),(2,7207),(4,FFFF) on cycles 3,6,9 after start; done=1, word_count=3, cpu_hold=0.
REQ-036 byte_valid low 4 cycles between high and low byte -> byte_ready stays 1, no write until low byte taken, data 16'h2607 correct.
REQ-037 DEPTH=4, five non-halt words offered -> 4 writes at addr 0,2,4,6; error=1, cpu_hold=1, fifth byte never accepted.
REQ-038 DEPTH=4, fourth word 16'hFFFF -> done=1, error=0, word_count=4.
REQ-039 reset_n low after high byte of second word -> all outputs zero asynchronously; new start, bytes 00 01 FF FF -> writes (0,0001),(2,FFFF).
REQ-040 start pulsed during LO -> ignored; wr_addr and word_count continue without clearing.
